// File: rtl/intlv_pkg.sv
// Shared constants for the QPP interleaver read-address generator: block sizes,
// QPP coefficients and FSM state encoding.
package intlv_pkg;

  localparam int unsigned ADDR_W = 13;

  localparam int unsigned K_SMALL  = 1056;
  localparam int unsigned K_LARGE  = 6144;
  localparam int unsigned F1_SMALL = 17;
  localparam int unsigned F2_SMALL = 66;
  localparam int unsigned F1_LARGE = 263;
  localparam int unsigned F2_LARGE = 480;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/qpp_mod_add.sv
// Modular adder y = (a + b) mod k for operands already reduced below k.
module qpp_mod_add #(
  parameter int unsigned Width = 13
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [Width-1:0] k,
  output logic [Width-1:0] y
);

  logic [Width:0] sum;

  // a, b < k so the sum is below 2k and one conditional subtract suffices
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) begin
      y = Width'(sum - {1'b0, k});
    end else begin
      y = sum[Width-1:0];
    end
  end

endmodule

// File: rtl/intlv_read_addr_gen.sv
// Generates LTE QPP-interleaved read addresses pi(i) = (f1*i + f2*i^2) mod K by
// second-order recursion. Optional INTLV_RD_LINEAR_MODE_EN adds a sequential bypass.
module intlv_read_addr_gen #(
  parameter int unsigned ADDR_W = intlv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              block_size,
  input  logic              read_enable,
`ifdef INTLV_RD_LINEAR_MODE_EN
  input  logic              linear_mode,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              last,
  output logic              busy,
  output logic              done
);

  import intlv_pkg::*;

  localparam logic [ADDR_W-1:0] KSmall    = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] KLarge    = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] G0Small   = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G0Large   = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] StepSmall = ADDR_W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] StepLarge = ADDR_W'((2 * F2_LARGE) % K_LARGE);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_sum, g_sum;
  logic              lin_sel;
  logic              is_last;
  logic              xfer;

`ifdef INTLV_RD_LINEAR_MODE_EN
  assign lin_sel = linear_mode;
`else
  assign lin_sel = 1'b0;
`endif

  // addr advances by g; g advances by 2*f2. Linear mode pins g=1, step=0 so addr tracks i.
  qpp_mod_add #(
    .Width (ADDR_W)
  ) u_addr_add (
    .a (addr_q),
    .b (g_q),
    .k (k_q),
    .y (addr_sum)
  );

  qpp_mod_add #(
    .Width (ADDR_W)
  ) u_g_add (
    .a (g_q),
    .b (step_q),
    .k (k_q),
    .y (g_sum)
  );

  assign is_last = (i_q == k_q - ADDR_W'(1));
  assign xfer    = (state_q == StRun) && read_enable;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    addr_d  = addr_q;
    g_d     = g_q;
    k_d     = k_q;
    step_d  = step_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          i_d     = '0;
          addr_d  = '0;
          k_d     = block_size ? KLarge : KSmall;
          if (lin_sel) begin
            g_d    = ADDR_W'(1);
            step_d = '0;
          end else begin
            g_d    = block_size ? G0Large : G0Small;
            step_d = block_size ? StepLarge : StepSmall;
          end
        end
      end
      StRun: begin
        if (xfer) begin
          if (is_last) begin
            state_d = StDone;
          end else begin
            i_d    = i_q + ADDR_W'(1);
            addr_d = addr_sum;
            g_d    = g_sum;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      addr_q  <= '0;
      g_q     <= '0;
      k_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      addr_q  <= addr_d;
      g_q     <= g_d;
      k_q     <= k_d;
      step_q  <= step_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == StRun);
  assign last       = addr_valid && is_last;
  assign busy       = (state_q == StRun) || (state_q == StDone);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_intlv_read_addr_gen.sv
// Directed bench for intlv_read_addr_gen: sequences checked against a closed-form QPP model.
module tb_intlv_read_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        block_size = 1'b0;
  logic        read_enable = 1'b0;
`ifdef INTLV_RD_LINEAR_MODE_EN
  logic        linear_mode = 1'b0;
`endif
  logic [12:0] addr;
  logic        addr_valid;
  logic        last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int first5[5];

  always #5 clk = ~clk;

  intlv_read_addr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .block_size  (block_size),
    .read_enable (read_enable),
`ifdef INTLV_RD_LINEAR_MODE_EN
    .linear_mode (linear_mode),
`endif
    .addr        (addr),
    .addr_valid  (addr_valid),
    .last        (last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int qpp(input int k, input int f1, input int f2, input int i);
    longint ii;
    ii = i;
    return int'((f1 * ii + f2 * ii * ii) % k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one block; abort_at >= 0 pulls reset after that many transfers.
  task automatic run_block(input bit bs, input bit lin, input bit stall, input int abort_at,
                           input string tag);
    int k, f1, f2, idx, bad, held_bad, last_bad, dup, busy_cyc, guard, exp;
    bit held;
    logic [12:0] held_addr;
    bit seen[6144];
    k  = bs ? 6144 : 1056;
    f1 = bs ? 263 : 17;
    f2 = bs ? 480 : 66;
    idx = 0; bad = 0; held_bad = 0; last_bad = 0; dup = 0; busy_cyc = 0; guard = 0;
    held = 1'b0;
    held_addr = '0;
    foreach (seen[j]) seen[j] = 1'b0;
    block_size = bs;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_first_valid"}, addr_valid, 1);
    check({tag, "_first_addr"}, addr, 0);
    while (idx < k && guard < 40000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      guard++;
      read_enable = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      // Mid-block start and block_size change must be ignored
      start      = (guard == 7);
      block_size = (guard == 7) ? ~bs : bs;
      if (busy) busy_cyc++;
      if (!addr_valid) begin
        bad++;
      end else begin
        if (held && addr != held_addr) held_bad++;
        if (last != (idx == k - 1)) last_bad++;
        exp = lin ? idx : qpp(k, f1, f2, idx);
        if (read_enable) begin
          if (int'(addr) != exp) bad++;
          if (seen[addr]) dup++;
          seen[addr] = 1'b1;
          if (idx < 5) first5[idx] = int'(addr);
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_addr = addr;
        end
      end
      tick();
    end
    read_enable = 1'b0;
    start = 1'b0;
    block_size = bs;
    if (abort_at >= 0) begin
      check({tag, "_abort_idx"}, idx, abort_at);
      check({tag, "_seq_err"}, bad, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check({tag, "_valid_after_reset"}, addr_valid, 0);
      check({tag, "_busy_after_reset"}, busy, 0);
      check({tag, "_done_after_reset"}, done, 0);
      check({tag, "_addr_after_reset"}, addr, 0);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (done || addr_valid || busy) bad++;
      end
      check({tag, "_idle_no_done"}, bad, 0);
      return;
    end
    check({tag, "_transfers"}, idx, k);
    check({tag, "_seq_err"}, bad, 0);
    check({tag, "_stall_hold_err"}, held_bad, 0);
    check({tag, "_last_err"}, last_bad, 0);
    check({tag, "_dup_addr"}, dup, 0);
    if (!stall) check({tag, "_busy_cycles"}, busy_cyc + 1, k + 1);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_done_busy"}, busy, 1);
    check({tag, "_done_valid"}, addr_valid, 0);
    // start during the DONE cycle must not launch a new block
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    tick();
    check({tag, "_start_in_done_ignored"}, addr_valid, 0);
  endtask

  initial begin
    // Reset held for two cycles with start asserted
    reset = 1'b0;
    start = 1'b1;
    tick();
    tick();
    check("rst_addr", addr, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("rst_start_ignored_valid", addr_valid, 0);
    check("rst_start_ignored_busy", busy, 0);

    run_block(1'b0, 1'b0, 1'b0, -1, "small");
    check("small_a1", first5[1], 83);
    check("small_a2", first5[2], 298);
    check("small_a3", first5[3], 645);
    check("small_a4", first5[4], 68);

    run_block(1'b1, 1'b0, 1'b0, -1, "large");
    check("large_a1", first5[1], 743);
    check("large_a2", first5[2], 2446);
    check("large_a3", first5[3], 5109);
    check("large_a4", first5[4], 2588);

    run_block(1'b0, 1'b0, 1'b1, -1, "stall");
    check("stall_a4", first5[4], 68);

    run_block(1'b0, 1'b0, 1'b0, 500, "abort");
    run_block(1'b0, 1'b0, 1'b0, -1, "restart");
    check("restart_a1", first5[1], 83);

`ifdef INTLV_RD_LINEAR_MODE_EN
    linear_mode = 1'b1;
    run_block(1'b0, 1'b1, 1'b0, -1, "linear");
    check("linear_a4", first5[4], 4);
    linear_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intlv_read_addr_gen.md
Name: intlv_read_addr_gen

Overview:
- Read-side companion to the interleaver write counter.
- After a block has been written linearly into the interleaver buffer, this block produces the read addresses in LTE QPP-interleaved order.
- QPP order: pi(i) = (f1*i + f2*i^2) mod K, for i = 0..K-1.
- Two block sizes: K=1056 (f1=17, f2=66) and K=6144 (f1=263, f2=480).
- Sits between the interleaver control FSM (start/done) and the buffer read port (addr/valid/ready).

Parameters:
- ADDR_W, 13, width of address and index (covers 0..6143).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a block read; honoured only in IDLE.
- block_size  in  1  0 = small (K=1056), 1 = large (K=6144); sampled on an accepted start.
- read_enable  in  1  downstream ready; an address transfers when addr_valid && read_enable.
- addr  out  13  current interleaved read address pi(i).
- addr_valid  out  1  addr holds a valid address.
- last  out  1  high with addr_valid when i = K-1.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse after the last address transfers.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; addr=0, addr_valid=0, last=0, busy=0, done=0; internal i=0, g=0.
- Reset mid-block aborts immediately and cleanly; no done pulse.
- States:
  - IDLE: start=1 latches K/f1/f2 from block_size; sets i=0, addr=0, g=(f1+f2) mod K; goes to RUN.
  - RUN: addr_valid=1.
  - DONE: one cycle, done=1, then back to IDLE.
- Latency: first address (0) is valid the cycle after start.
- RUN, on transfer (addr_valid && read_enable):
  - If i = K-1: go to DONE.
  - Otherwise: i<=i+1; addr<=(addr+g) mod K; g<=(g+2*f2) mod K.
- RUN, no transfer: addr, i and g hold, and addr_valid stays high (AXI-style stall). Downstream may stall indefinitely.
- Modular arithmetic:
  - Operands are always < K, so each sum is < 2K and fits in 14 bits.
  - Reduce by one conditional subtract of K; no multipliers.
- last = addr_valid && (i == K-1).
- Throughput: one address per cycle while read_enable=1.
- start while busy is ignored; a block_size change mid-block is ignored.
- start in the same cycle as the DONE state is ignored; start must be re-asserted in IDLE.

Optional Feature:
- Macro INTLV_RD_LINEAR_MODE_EN.
- Defined:
  - Adds input port linear_mode (1 bit), sampled with start.
  - If linear_mode=1, addr=i, i.e. sequential 0..K-1 (de-interleave bypass / debug readback).
  - Handshake, last and done timing are identical to normal mode.
- Undefined: the port is absent and QPP order is always used.

Decomposition:
- Package intlv_pkg:
  - K_SMALL=1056, K_LARGE=6144.
  - F1_SMALL=17, F2_SMALL=66, F1_LARGE=263, F2_LARGE=480.
  - ADDR_W=13.
  - State encoding IDLE/RUN/DONE.
- Sub-module qpp_mod_add (a, b, k -> (a+b) mod k, combinational). Instantiated twice: once for the address recursion, once for the g recursion.

Test Plan:
- reset=0 for 2 cycles, then release -> all outputs 0, state IDLE; start asserted during reset is ignored.
- block_size=0, start, read_enable=1 -> addr sequence 0, 83, 298, 645, 68, ...; last on the 1056th address; done pulse one cycle later; busy high for 1057 cycles.
- block_size=1, start, read_enable=1 -> addr 0, 743, 2446, 5109, 2588, ...; 6144 transfers; every address 0..6143 seen exactly once (permutation check against a software QPP model).
- block_size=0, read_enable toggled randomly -> addr held stable while addr_valid && !read_enable; sequence identical to the unstalled run.
- K=1056 run, reset=0 at transfer 500 -> next cycle IDLE, addr_valid=0, no done; a new start then begins again from addr 0.
- INTLV_RD_LINEAR_MODE_EN defined, linear_mode=1, block_size=0 -> addr 0, 1, 2, ..., 1055; last on 1055; plus a start pulse during RUN -> ignored.
